rotor_stage: RTL and testbench
==============================

Name: rotor_stage

Overview:
Parametrised Enigma rotor stage, successor to the fixed 26-letter rotor. It has a configurable alphabet size, ring setting and notch, a forward and an inverse permutation path, odometer carry to the next rotor, and valid/ready handshakes on symbol and output. The inverse table is built in hardware from the forward wiring at configuration time, and the wiring is checked to be a true permutation. Rotor stages are chained by step_out -> step_in to form the rotor bank.

Parameters:
ALPHA, 26, alphabet size (2..64)
SYM_W, 8, symbol width (ASCII)
BASE, 65, code of first letter ('A')
IDX_W, $clog2(ALPHA), index width (derived; not overridden)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
cfg_we  in  1  load configuration (honoured only when cfg_ready=1)
cfg_ready  out  1  high in IDLE with no output pending
cfg_wiring  in  ALPHA*IDX_W  forward table; entry k at bits [k*IDX_W +: IDX_W]
cfg_pos  in  IDX_W  initial rotor position
cfg_ring  in  IDX_W  ring setting
cfg_notch  in  IDX_W  turnover position
cfg_err  out  1  sticky: last wiring was not a permutation
step_in  in  1  advance one position (keypress or carry)
key_step  in  1  keypress strobe (used only with the optional feature)
step_out  out  1  one-cycle carry to the next rotor
in_valid  in  1  symbol offered
in_ready  out  1  symbol accepted when in_valid & in_ready
in_sym  in  SYM_W  input symbol
in_dir  in  1  0 forward, 1 inverse (reflected return path)
out_valid  out  1  result available
out_ready  in  1  downstream accepts
out_sym  out  SYM_W  result symbol
pos  out  IDX_W  current position

Behaviour:
- Reset values:
  - FSM=IDLE; pos=0, ring=0, notch=ALPHA-1.
  - Forward and inverse tables = identity.
  - cfg_err=0, step_out=0, out_valid=0, out_sym=0, in_ready=1, cfg_ready=1.
- FSM has three states:
  - IDLE: in_ready=1; cfg_we -> BUILD; an accepted symbol -> OUT.
  - BUILD: exactly ALPHA cycles; in_ready=0 and cfg_ready=0; returns to IDLE.
  - OUT: out_valid=1, out_sym held stable; on out_ready -> IDLE.
- Config load (cfg_we in IDLE):
  - Latch pos, ring and notch from cfg_pos, cfg_ring and cfg_notch; copy wiring; clear the seen-bitmap and cfg_err.
  - BUILD cycle k: inv[fwd[k]] <= k, then set seen[fwd[k]].
  - If fwd[k] >= ALPHA or seen[fwd[k]] is already set: set cfg_err.
  - At the end of BUILD with cfg_err=1: both tables revert to identity.
  - cfg_we outside IDLE is ignored.
- Mapping (sampled at acceptance):
  - c = in_sym - BASE. If in_sym < BASE or in_sym >= BASE+ALPHA, out_sym = in_sym unchanged.
  - Otherwise:
    - shift = (pos - ring) mod ALPHA
    - x = (c + shift) mod ALPHA
    - y = fwd[x] if in_dir=0, else inv[x]
    - out_sym = ((y - shift) mod ALPHA) + BASE
  - Latency: accepted at edge T -> out_valid high after edge T+1. Maximum throughput is 1 symbol per 2 cycles.
- Arithmetic: operands < ALPHA, computed at IDX_W+1 bits; a single conditional add/subtract of ALPHA gives the mod. Subtraction adds ALPHA before subtracting.
- Stepping:
  - step_in is honoured in every state except BUILD; during BUILD it is dropped.
  - Step: pos <= (pos==ALPHA-1) ? 0 : pos+1.
  - step_out is registered and pulses the cycle after a step taken from pos==notch.
  - step_in in the same cycle as acceptance: mapping uses the pre-step pos.
- Reset mid-BUILD or mid-OUT returns to the reset values above; the configuration is lost.

Optional Feature:
ROTOR_DOUBLE_STEP_EN
- Defined: on key_step with pos==notch, the rotor steps and pulses step_out even if step_in=0. This models the Enigma middle-rotor double step. key_step and step_in together produce one step only.
- Undefined: key_step is ignored and its input is left unused.

Decomposition:
- Package rotor_pkg holds:
  - state enum {IDLE, BUILD, OUT}
  - defaults ALPHA_DEF=26, BASE_DEF=65
  - functions mod_add(a,b,n) and mod_sub(a,b,n)
- Sub-module rotor_perm_table holds the fwd and inv tables, the seen-bitmap, the BUILD counter and error detection. It exposes fwd_rd(x), inv_rd(x), build_done and perm_err.

Test Plan:
- Wiring EKMFLGDQVZNTOWYHXUSPAIBRCJ, pos=0, ring=0:
  - forward 'A'(65) -> 'E'(69)
  - inverse 'E' -> 'A'
  - out_valid rises 1 cycle after acceptance
- Same wiring, pos=1: forward 'A' -> 'J'. With ring=1 and pos=1: forward 'A' -> 'E'.
- notch=16, pos=16, step_in pulse -> pos=17 and step_out pulses 1 cycle later. At pos=25, step_in -> pos=0 and no step_out.
- Wiring with entries 0 and 1 both equal 4 -> cfg_err=1 after 26 BUILD cycles, tables identity, 'C' -> 'C'. The next valid cfg_we clears cfg_err.
- '#'(35) and 'a'(97) pass through unchanged. With out_ready=0 for 5 cycles, out_sym is held and in_ready=0.
- With ROTOR_DOUBLE_STEP_EN, notch=4, pos=4, key_step=1, step_in=0 -> pos=5 and step_out pulses. Without the macro, pos stays 4.

Source files
------------

// File: rtl/rotor_pkg.sv
// Shared types, defaults and modular-arithmetic helpers for the rotor stage.
package rotor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUILD = 2'd1,
    OUT   = 2'd2
  } state_t;

  localparam int ALPHA_DEF = 26;
  localparam int BASE_DEF  = 65;

  // Width of the modular helpers: one bit above the widest index (ALPHA <= 64),
  // so a + b and a + n never overflow before the single correction step.
  localparam int MOD_W = 7;

  // (a + b) mod n for a, b < n
  function automatic logic [MOD_W-1:0] mod_add(input logic [MOD_W-1:0] a,
                                               input logic [MOD_W-1:0] b,
                                               input logic [MOD_W-1:0] n);
    logic [MOD_W-1:0] s;
    s = a + b;
    if (s >= n) s = s - n;
    return s;
  endfunction

  // (a - b) mod n for a, b < n; n is added first so the difference stays positive
  function automatic logic [MOD_W-1:0] mod_sub(input logic [MOD_W-1:0] a,
                                               input logic [MOD_W-1:0] b,
                                               input logic [MOD_W-1:0] n);
    logic [MOD_W-1:0] d;
    d = a + n;
    d = d - b;
    if (d >= n) d = d - n;
    return d;
  endfunction

endpackage

// File: rtl/rotor_perm_table.sv
// Forward/inverse rotor tables. On i_start the forward wiring is copied in, then
// one entry per cycle is inverted and checked for duplicates/out-of-range values.
// A bad wiring leaves both tables as identity and raises the sticky error.
module rotor_perm_table
  import rotor_pkg::*;
#(
  parameter int ALPHA = ALPHA_DEF,
  parameter int IDX_W = $clog2(ALPHA)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_start,
  input  logic [ALPHA*IDX_W-1:0] i_wiring,
  input  logic [IDX_W-1:0]       i_fwd_addr,
  input  logic [IDX_W-1:0]       i_inv_addr,
  output logic [IDX_W-1:0]       o_fwd_rd,
  output logic [IDX_W-1:0]       o_inv_rd,
  output logic                   o_build_done,
  output logic                   o_perm_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ALPHA - 1);
  localparam logic [IDX_W:0]   ALPHA_X  = (IDX_W + 1)'(ALPHA);

  logic [IDX_W-1:0] r_fwd [ALPHA];
  logic [IDX_W-1:0] r_inv [ALPHA];
  logic [ALPHA-1:0] r_seen;
  logic [IDX_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_err;

  logic [IDX_W-1:0] w_entry;
  logic             w_bad;
  logic             w_last;

  assign w_entry      = r_fwd[r_cnt];
  assign w_bad        = ({1'b0, w_entry} >= ALPHA_X) || r_seen[w_entry];
  assign w_last       = (r_cnt == LAST_IDX);
  assign o_build_done = r_busy && w_last;
  assign o_perm_err   = r_err;
  assign o_fwd_rd     = r_fwd[i_fwd_addr];
  assign o_inv_rd     = r_inv[i_inv_addr];

  // Load wiring, then walk it once building the inverse and checking uniqueness
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < ALPHA; k++) begin
        r_fwd[k] <= IDX_W'(k);
        r_inv[k] <= IDX_W'(k);
      end
      r_seen <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_err  <= 1'b0;
    end else if (i_start) begin
      for (int k = 0; k < ALPHA; k++) begin
        r_fwd[k] <= i_wiring[k*IDX_W +: IDX_W];
      end
      r_seen <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b1;
      r_err  <= 1'b0;
    end else if (r_busy) begin
      if (w_bad) begin
        r_err <= 1'b1;
      end else begin
        r_inv[w_entry]  <= r_cnt;
        r_seen[w_entry] <= 1'b1;
      end
      if (w_last) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
        // the error seen on this final entry counts too
        if (r_err || w_bad) begin
          for (int k = 0; k < ALPHA; k++) begin
            r_fwd[k] <= IDX_W'(k);
            r_inv[k] <= IDX_W'(k);
          end
        end
      end else begin
        r_cnt <= r_cnt + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/rotor_stage.sv
// Parametrised Enigma rotor stage: ring/position offset mapping through a
// forward or inverse table, odometer carry, valid/ready handshakes.
// Optional: define ROTOR_DOUBLE_STEP_EN to let key_step advance a rotor sitting
// on its notch (middle-rotor double step); otherwise key_step is ignored.
module rotor_stage
  import rotor_pkg::*;
#(
  parameter  int ALPHA = ALPHA_DEF,
  parameter  int SYM_W = 8,
  parameter  int BASE  = BASE_DEF,
  localparam int IDX_W = $clog2(ALPHA)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cfg_we,
  output logic                   cfg_ready,
  input  logic [ALPHA*IDX_W-1:0] cfg_wiring,
  input  logic [IDX_W-1:0]       cfg_pos,
  input  logic [IDX_W-1:0]       cfg_ring,
  input  logic [IDX_W-1:0]       cfg_notch,
  output logic                   cfg_err,
  input  logic                   step_in,
  input  logic                   key_step,
  output logic                   step_out,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SYM_W-1:0]       in_sym,
  input  logic                   in_dir,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SYM_W-1:0]       out_sym,
  output logic [IDX_W-1:0]       pos
);

  localparam logic [IDX_W-1:0] LAST_POS = IDX_W'(ALPHA - 1);
  localparam logic [MOD_W-1:0] ALPHA_M  = MOD_W'(ALPHA);
  localparam logic [SYM_W:0]   BASE_X   = (SYM_W + 1)'(BASE);
  localparam logic [SYM_W:0]   LIMIT_X  = (SYM_W + 1)'(BASE + ALPHA);

  state_t           r_state, w_state_next;
  logic [IDX_W-1:0] r_pos, r_ring, r_notch;
  logic [SYM_W-1:0] r_out_sym;
  logic             r_step_out;

  logic             w_start, w_accept, w_build_done, w_step_req, w_step;
  logic [SYM_W:0]   w_sym_ext;
  logic             w_in_range;
  logic [IDX_W-1:0] w_c, w_shift, w_x, w_y, w_fwd_rd, w_inv_rd, w_letter;
  logic [SYM_W-1:0] w_mapped;

  rotor_perm_table #(.ALPHA(ALPHA), .IDX_W(IDX_W)) u_table (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_start      (w_start),
    .i_wiring     (cfg_wiring),
    .i_fwd_addr   (w_x),
    .i_inv_addr   (w_x),
    .o_fwd_rd     (w_fwd_rd),
    .o_inv_rd     (w_inv_rd),
    .o_build_done (w_build_done),
    .o_perm_err   (cfg_err)
  );

  // Symbol mapping from the pre-step position, evaluated at acceptance
  assign w_sym_ext  = {1'b0, in_sym};
  assign w_in_range = (w_sym_ext >= BASE_X) && (w_sym_ext < LIMIT_X);
  assign w_c        = IDX_W'(w_sym_ext - BASE_X);
  assign w_shift    = IDX_W'(mod_sub(MOD_W'(r_pos), MOD_W'(r_ring), ALPHA_M));
  assign w_x        = IDX_W'(mod_add(MOD_W'(w_c), MOD_W'(w_shift), ALPHA_M));
  assign w_y        = in_dir ? w_inv_rd : w_fwd_rd;
  assign w_letter   = IDX_W'(mod_sub(MOD_W'(w_y), MOD_W'(w_shift), ALPHA_M));
  assign w_mapped   = w_in_range ? (SYM_W'(w_letter) + SYM_W'(BASE)) : in_sym;

`ifdef ROTOR_DOUBLE_STEP_EN
  assign w_step_req = step_in || (key_step && (r_pos == r_notch));
`else
  logic w_key_step_unused;
  assign w_key_step_unused = key_step;
  assign w_step_req = step_in;
`endif
  // A configuration load reloads the position, so a coincident step is dropped
  assign w_step = w_step_req && (r_state != BUILD) && !w_start;

  assign pos      = r_pos;
  assign out_sym  = r_out_sym;
  assign step_out = r_step_out;

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  // Next state and handshake outputs; a configuration write takes priority
  // over a symbol in IDLE, so in_ready drops while cfg_we is asserted
  always_comb begin
    w_state_next = r_state;
    cfg_ready    = 1'b0;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    w_start      = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        cfg_ready = 1'b1;
        in_ready  = !cfg_we;
        if (cfg_we) begin
          w_start      = 1'b1;
          w_state_next = BUILD;
        end else if (in_valid) begin
          w_accept     = 1'b1;
          w_state_next = OUT;
        end
      end
      BUILD: if (w_build_done) w_state_next = IDLE;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Position/ring/notch registers, stepping and carry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pos      <= '0;
      r_ring     <= '0;
      r_notch    <= LAST_POS;
      r_step_out <= 1'b0;
    end else begin
      r_step_out <= w_step && (r_pos == r_notch);
      if (w_start) begin
        r_pos   <= cfg_pos;
        r_ring  <= cfg_ring;
        r_notch <= cfg_notch;
      end else if (w_step) begin
        r_pos <= (r_pos == LAST_POS) ? '0 : r_pos + IDX_W'(1);
      end
    end
  end

  // Output symbol captured at acceptance and held through OUT
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      r_out_sym <= '0;
    else if (w_accept) r_out_sym <= w_mapped;
  end

endmodule

// File: tb/tb_rotor_stage.sv
// Directed bench for rotor_stage (26 letters, base 'A') with hand-computed results.
module tb_rotor_stage;

  localparam int ALPHA = 26;
  localparam int IDX_W = 5;
  localparam int WW    = ALPHA * IDX_W;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             cfg_we = 1'b0;
  logic             cfg_ready;
  logic [WW-1:0]    cfg_wiring = '0;
  logic [IDX_W-1:0] cfg_pos = '0, cfg_ring = '0, cfg_notch = '0;
  logic             cfg_err;
  logic             step_in = 1'b0, key_step = 1'b0, step_out;
  logic             in_valid = 1'b0, in_ready;
  logic [7:0]       in_sym = '0;
  logic             in_dir = 1'b0;
  logic             out_valid, out_ready = 1'b0;
  logic [7:0]       out_sym;
  logic [IDX_W-1:0] pos;

  int n_vec = 0;
  int n_err = 0;

  logic [WW-1:0] wiring_i;
  logic [WW-1:0] wiring_bad;

  rotor_stage dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cfg_we     (cfg_we),
    .cfg_ready  (cfg_ready),
    .cfg_wiring (cfg_wiring),
    .cfg_pos    (cfg_pos),
    .cfg_ring   (cfg_ring),
    .cfg_notch  (cfg_notch),
    .cfg_err    (cfg_err),
    .step_in    (step_in),
    .key_step   (key_step),
    .step_out   (step_out),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sym     (in_sym),
    .in_dir     (in_dir),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sym    (out_sym),
    .pos        (pos)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [WW-1:0] wire_from(input string s);
    logic [WW-1:0] w;
    w = '0;
    for (int k = 0; k < ALPHA; k++) w[k*IDX_W +: IDX_W] = IDX_W'(s[k] - 8'd65);
    return w;
  endfunction

  function automatic logic [WW-1:0] wire_ident();
    logic [WW-1:0] w;
    w = '0;
    for (int k = 0; k < ALPHA; k++) w[k*IDX_W +: IDX_W] = IDX_W'(k);
    return w;
  endfunction

  // Load a configuration and count BUILD cycles; optionally poke step_in inside BUILD
  task automatic cfg_load(input logic [WW-1:0] w, input int p, input int r, input int nt,
                          input bit poke_step);
    int n;
    n = 0;
    while (!cfg_ready && n < 100) begin @(posedge clk); #1; n++; end
    cfg_wiring = w;
    cfg_pos    = IDX_W'(p);
    cfg_ring   = IDX_W'(r);
    cfg_notch  = IDX_W'(nt);
    cfg_we     = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    if (poke_step) step_in = 1'b1;
    n = 0;
    while (!cfg_ready && n < 100) begin @(posedge clk); #1; step_in = 1'b0; n++; end
    step_in = 1'b0;
    chk("build_cycles", n, 26);
    if (poke_step) chk("build_step_drop", pos, p);
    $display("cfg: pos=%0d ring=%0d notch=%0d err=%0d build_cycles=%0d", p, r, nt, cfg_err, n);
  endtask

  // Offer one symbol, check latency and result, then drain it
  task automatic send(input string tag, input logic [7:0] sym, input logic dir,
                      input logic [7:0] exp);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    chk({tag, "_in_ready"}, in_ready, 1);
    in_valid = 1'b1;
    in_sym   = sym;
    in_dir   = dir;
    chk({tag, "_ov_pre"}, out_valid, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_ov"}, out_valid, 1);
    chk(tag, out_sym, exp);
    $display("xfer %s: in=%0d dir=%0d out=%0d", tag, sym, dir, out_sym);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic step_pulse(input logic si, input logic ks);
    step_in  = si;
    key_step = ks;
    @(posedge clk); #1;
    step_in  = 1'b0;
    key_step = 1'b0;
  endtask

  initial begin
    wiring_i   = wire_from("EKMFLGDQVZNTOWYHXUSPAIBRCJ");
    wiring_bad = wire_ident();
    wiring_bad[0 +: IDX_W]     = 5'd4;
    wiring_bad[IDX_W +: IDX_W] = 5'd4;

    #22 reset_n = 1'b1;
    @(posedge clk); #1;

    // reset state
    chk("rst_pos", pos, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sym", out_sym, 0);
    chk("rst_step_out", step_out, 0);
    chk("rst_cfg_err", cfg_err, 0);
    send("rst_ident_C", 8'd67, 1'b0, 8'd67);

    // rotor I at pos 0, ring 0
    cfg_load(wiring_i, 0, 0, 25, 1'b0);
    send("fwd_A", 8'd65, 1'b0, 8'd69);
    send("inv_E", 8'd69, 1'b1, 8'd65);
    send("fwd_Z", 8'd90, 1'b0, 8'd74);
    send("inv_J", 8'd74, 1'b1, 8'd90);

    // position and ring offsets (step during BUILD must be dropped)
    cfg_load(wiring_i, 1, 0, 25, 1'b1);
    send("pos1_A", 8'd65, 1'b0, 8'd74);
    cfg_load(wiring_i, 1, 1, 25, 1'b0);
    send("ring1_A", 8'd65, 1'b0, 8'd69);
    cfg_load(wiring_i, 25, 0, 25, 1'b0);
    send("pos25_A", 8'd65, 1'b0, 8'd75);

    // stepping and carry
    cfg_load(wiring_i, 16, 0, 16, 1'b0);
    step_pulse(1'b1, 1'b0);
    chk("notch_pos", pos, 17);
    chk("notch_step_out", step_out, 1);
    @(posedge clk); #1;
    chk("notch_step_out_end", step_out, 0);
    cfg_load(wiring_i, 25, 0, 16, 1'b0);
    step_pulse(1'b1, 1'b0);
    chk("wrap_pos", pos, 0);
    chk("wrap_step_out", step_out, 0);

    // step in the acceptance cycle: mapping uses pre-step position
    cfg_load(wiring_i, 0, 0, 25, 1'b0);
    in_valid = 1'b1; in_sym = 8'd65; in_dir = 1'b0; step_in = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; step_in = 1'b0;
    chk("acc_step_sym", out_sym, 69);
    chk("acc_step_pos", pos, 1);
    $display("xfer acc_step: in=65 dir=0 out=%0d", out_sym);
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;

    // bad wiring: duplicate entry -> sticky error, identity tables
    cfg_load(wiring_bad, 0, 0, 25, 1'b0);
    chk("bad_cfg_err", cfg_err, 1);
    send("bad_C", 8'd67, 1'b0, 8'd67);
    send("bad_A", 8'd65, 1'b0, 8'd65);
    send("bad_inv_E", 8'd69, 1'b1, 8'd69);
    cfg_load(wiring_i, 0, 0, 25, 1'b0);
    chk("good_cfg_err", cfg_err, 0);
    send("good_A", 8'd65, 1'b0, 8'd69);

    // pass-through outside the alphabet, including both edges
    send("pass_hash", 8'd35, 1'b0, 8'd35);
    send("pass_a", 8'd97, 1'b0, 8'd97);
    send("pass_at", 8'd64, 1'b0, 8'd64);
    send("pass_lbr", 8'd91, 1'b1, 8'd91);

    // back-pressure: output held while out_ready stays low
    in_valid = 1'b1; in_sym = 8'd90; in_dir = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("hold_sym", out_sym, 74);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_valid", out_valid, 1);
      in_sym = 8'(65 + i);
      @(posedge clk); #1;
    end
    $display("xfer hold: in=90 dir=0 out=%0d", out_sym);
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    chk("hold_release", out_valid, 0);

    // key_step on the notch
    cfg_load(wiring_i, 4, 0, 4, 1'b0);
    step_pulse(1'b0, 1'b1);
`ifdef ROTOR_DOUBLE_STEP_EN
    chk("dbl_key_pos", pos, 5);
    chk("dbl_key_step_out", step_out, 1);
`else
    chk("dbl_key_pos", pos, 4);
    chk("dbl_key_step_out", step_out, 0);
`endif
    cfg_load(wiring_i, 4, 0, 4, 1'b0);
    step_pulse(1'b1, 1'b1);
    chk("dbl_both_pos", pos, 5);
    chk("dbl_both_step_out", step_out, 1);

    // reset in the middle of BUILD loses the configuration
    cfg_wiring = wiring_i; cfg_pos = 5'd7; cfg_ring = '0; cfg_notch = 5'd25;
    cfg_we = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b0;
    #2;
    chk("midrst_pos", pos, 0);
    chk("midrst_cfg_ready", cfg_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    send("midrst_A", 8'd65, 1'b0, 8'd65);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global guard so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
